// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/issue stage with operand forwarding, load-use interlock and ID/EX register
module id_ex_stage #(
    parameter int LEN_REG_FILE_ADDR = 5,
    parameter int LEN_WORD          = 32,
    parameter int LEN_CTRL          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rs,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rt,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rd,
    input  logic [15:0]                  id_imm16,
    input  logic [LEN_CTRL-1:0]          id_ctrl,
    input  logic                         id_mem_read,
    input  logic                         flush,
    output logic [LEN_REG_FILE_ADDR-1:0] src_1,
    output logic [LEN_REG_FILE_ADDR-1:0] src_2,
    input  logic [LEN_WORD-1:0]          read_data_1,
    input  logic [LEN_WORD-1:0]          read_data_2,
    input  logic                         exm_write_en,
    input  logic [LEN_REG_FILE_ADDR-1:0] exm_dst,
    input  logic [LEN_WORD-1:0]          exm_data,
    input  logic                         mwb_write_en,
    input  logic [LEN_REG_FILE_ADDR-1:0] mwb_dst,
    input  logic [LEN_WORD-1:0]          mwb_data,
    output logic                         stall,
    output logic                         ex_valid,
    output logic [LEN_WORD-1:0]          ex_op_a,
    output logic [LEN_WORD-1:0]          ex_op_b,
    output logic [LEN_WORD-1:0]          ex_imm,
    output logic [LEN_REG_FILE_ADDR-1:0] ex_rt,
    output logic [LEN_REG_FILE_ADDR-1:0] ex_rd,
    output logic [LEN_CTRL-1:0]          ex_ctrl,
    output logic                         ex_mem_read
);

    localparam logic [LEN_REG_FILE_ADDR-1:0] REG_ZERO = '0;

    logic [LEN_WORD-1:0] op_a;
    logic [LEN_WORD-1:0] op_b;
    logic [LEN_WORD-1:0] imm_ext;
    logic                bubble;

    assign src_1 = id_rs;
    assign src_2 = id_rt;

    assign imm_ext = {{(LEN_WORD-16){id_imm16[15]}}, id_imm16};

    // Forwarding mux per operand: EX/MEM beats MEM/WB beats the register file; r0 always reads 0.
    // MEM/WB is needed because the register file's combinational read lags its own write by a cycle.
    always_comb begin
        op_a = read_data_1;
        if (id_rs == REG_ZERO)
            op_a = '0;
        else if (exm_write_en && exm_dst != REG_ZERO && exm_dst == id_rs)
            op_a = exm_data;
        else if (mwb_write_en && mwb_dst != REG_ZERO && mwb_dst == id_rs)
            op_a = mwb_data;

        op_b = read_data_2;
        if (id_rt == REG_ZERO)
            op_b = '0;
        else if (exm_write_en && exm_dst != REG_ZERO && exm_dst == id_rt)
            op_b = exm_data;
        else if (mwb_write_en && mwb_dst != REG_ZERO && mwb_dst == id_rt)
            op_b = mwb_data;
    end

    // Load-use interlock: the load in ID/EX has no data yet, so hold ID one cycle and let EX/MEM forward next.
    always_comb begin
        stall = id_valid && ex_valid && ex_mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

    assign bubble = flush || stall;

    // ID/EX pipeline register: a bubble on flush or stall, otherwise capture the resolved instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_imm      <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_imm      <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_op_a     <= op_a;
            ex_op_b     <= op_b;
            ex_imm      <= imm_ext;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
            ex_mem_read <= id_valid && id_mem_read;
        end
    end

endmodule
